operand_regfile: RTL and testbench
==================================

# operand_regfile

Register file and operand-issue stage sitting directly upstream of the 19-bit ALU. Holds the datapath's eight general registers, drives `ALU_OP`/`a_in`/`b_in` from an issued instruction, and writes the ALU result back into the destination register, aligned to the ALU's one-cycle registered latency. Read-after-write hazards are detected and the issue port is stalled, or the hazard is resolved by forwarding when `OPREG_BYPASS_EN` is defined. It also latches the ALU zero flag for the control unit's branch logic.

## Interface
- `DATA_W`, 19, datapath width
- `NREG`, 8, register count; R0 reads as zero
- `ADDR_W`, 3, register address width
- `clk` in 1: single clock, all state on posedge
- `RST` in 1: reset, synchronous, active-high
- `issue_valid` in 1: instruction presented
- `issue_ready` out 1: instruction accepted this cycle if `issue_valid`
- `op_in` in 4: ALU opcode (`aluopdef.v` encodings)
- `rs_a`, `rs_b`, `rd` in ADDR_W: source A, source B, destination
- `use_imm` in 1: B operand is `imm_in`, `rs_b` ignored
- `imm_in` in DATA_W: immediate
- `wb_en` in 1: write result to `rd`
- `ALU_OP` out 4, `a_out` out DATA_W, `b_out` out DATA_W: registered, to ALU
- `alu_result` in DATA_W, `alu_z` in 1: from ALU `alu_out`/`z_flag`
- `ext_wr_en` in 1, `ext_wr_addr` in ADDR_W, `ext_wr_data` in DATA_W: memory-load write port
- `ext_wr_ready` out 1: external write accepted this cycle
- `z_out` out 1: latched zero flag
- `busy` out 1: any writeback in flight

## Operation
- Issue fires when `issue_valid & issue_ready`. At that edge, `ALU_OP<=op_in`, `a_out<=R[rs_a]`, `b_out<=use_imm?imm_in:R[rs_b]`; pipe stage S1 `<= {1, wb_en, rd}`.
- Cycle with no fire: `ALU_OP<=NOP` (4'hF, added to `aluopdef.v`, hits the ALU default), `a_out`/`b_out` hold, S1 valid `<=0`.
- S1 shifts to S2 each edge. In the cycle where S2 is valid, `alu_result` is that op's result. At the end of that cycle, if `wb_en` and `rd!=0`, `R[rd]<=alu_result`, and `z_out<=alu_z` (any valid S2, regardless of `wb_en`).
- R0 always reads 0; writes to R0 are discarded (ALU and external).
- Hazard: a source (`rs_a`, and `rs_b` when `!use_imm`), nonzero, equals `rd` of a valid, `wb_en` entry in S1 or S2.
- Without bypass: `issue_ready=!RST & !hazard`.
- `ext_wr_ready = !(S2 valid & S2 wb_en & S2 rd!=0)`; ALU writeback wins a same-cycle conflict. An accepted external write updates the register at that edge.
- A same-cycle read of the register being externally written returns the old value.
- `busy = S1 valid | S2 valid`.
- Arithmetic is the ALU's job; this block only moves DATA_W-bit values with no width change.

## Timing
- Issue at edge N; ALU captures at N+1; result is on `alu_result` during cycle N+2 and written at edge N+2. A dependent issue reads the new value from cycle N+3 without bypass, i.e. two stall cycles.
- RST, sampled at an edge, clears all registers, S1/S2, `a_out`, `b_out` and `z_out` to 0, and sets `ALU_OP=NOP`.
- While RST is high, `issue_ready=0` and `ext_wr_ready=0`. In-flight writebacks are dropped.
- Back-to-back independent issues: one per cycle, no bubbles.

## Configuration
- `OPREG_BYPASS_EN` defined: a source matching valid S2 `rd` with `wb_en` takes `alu_result` directly, and S2 matches no longer stall. Only an S1 match stalls, for one cycle. If both match, S1 governs.
- Not defined: every hazard stalls, as described in Operation.

## Structure
- Shared package/include: `DATA_W`, `ADDR_W`, `NREG`, the `NOP` opcode, and the pipe-entry record `{valid, wb_en, rd}`.
- One sub-module, `opreg_hazard`: combinational hazard/forward-select logic from S1, S2 and the sources, producing `stall`, `fwd_a` and `fwd_b`.

## Test plan
- Reset, then `ext_wr` R1=5 and R2=3; issue ADDR rd=R3, rs=R1,R2. Required: `a_out=5`, `b_out=3` one cycle later; R3=8 at N+2; `z_out=0`.
- SUBR R4=R1-R1: R4=0 and `z_out=1`. Then ADDI R5=R0+7: `z_out=0`, and R0 still reads 0 after an `ext_wr` to R0 of 9.
- Dependent ADDR R6=R3+R3 issued right after R3's write. Required: 2 stall cycles without the macro; with `OPREG_BYPASS_EN`, 1 stall cycle and `a_out=b_out=8`.
- `ext_wr_en` to R7 on the same cycle as an S2 writeback to R2. Required: `ext_wr_ready=0`, R2 written, R7 written one cycle later when retried.
- RST asserted at N+1 of an in-flight ADDR. Required: destination stays 0, `ALU_OP=NOP`, `busy=0`, `z_out=0`.
- Eight independent INCR ops back-to-back. Required: `issue_ready` high throughout and eight writebacks on consecutive cycles.

Source files
------------

// File: rtl/operand_regfile_pkg.sv
// operand_regfile_pkg: shared widths, NOP opcode and writeback pipe-entry record
package operand_regfile_pkg;
  localparam int DATA_W = 19;
  localparam int NREG = 8;
  localparam int ADDR_W = 3;
  localparam logic [3:0] NOP = 4'hF;
  typedef struct packed {
    logic valid;
    logic wb_en;
    logic [ADDR_W-1:0] rd;
  } pipe_t;
endpackage

// File: rtl/operand_regfile_hazard.sv
// opreg_hazard: RAW detection against S1/S2 and forward select (OPREG_BYPASS_EN)
module opreg_hazard
  import operand_regfile_pkg::*;
(
  input  pipe_t             s1,
  input  pipe_t             s2,
  input  logic [ADDR_W-1:0] rs_a,
  input  logic [ADDR_W-1:0] rs_b,
  input  logic              use_imm,
  output logic              stall,
  output logic              fwd_a,
  output logic              fwd_b
);
  logic w1, w2, m1a, m1b, m2a, m2b;
  // source-vs-destination matches; R0 never creates a dependency
  always_comb begin
    w1 = s1.valid & s1.wb_en & (s1.rd != '0);
    w2 = s2.valid & s2.wb_en & (s2.rd != '0);
    m1a = w1 & (rs_a == s1.rd);
    m2a = w2 & (rs_a == s2.rd);
    m1b = w1 & !use_imm & (rs_b == s1.rd);
    m2b = w2 & !use_imm & (rs_b == s2.rd);
`ifdef OPREG_BYPASS_EN
    stall = m1a | m1b;
    fwd_a = m2a & !m1a;
    fwd_b = m2b & !m1b;
`else
    stall = m1a | m1b | m2a | m2b;
    fwd_a = 1'b0;
    fwd_b = 1'b0;
`endif
  end
endmodule

// File: rtl/operand_regfile.sv
// operand_regfile: register file + operand issue to the ALU, forwarding under OPREG_BYPASS_EN
module operand_regfile
  import operand_regfile_pkg::*;
(
  input  logic              clk,
  input  logic              RST,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [3:0]        op_in,
  input  logic [ADDR_W-1:0] rs_a,
  input  logic [ADDR_W-1:0] rs_b,
  input  logic [ADDR_W-1:0] rd,
  input  logic              use_imm,
  input  logic [DATA_W-1:0] imm_in,
  input  logic              wb_en,
  output logic [3:0]        ALU_OP,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_z,
  input  logic              ext_wr_en,
  input  logic [ADDR_W-1:0] ext_wr_addr,
  input  logic [DATA_W-1:0] ext_wr_data,
  output logic              ext_wr_ready,
  output logic              z_out,
  output logic              busy
);
  logic [DATA_W-1:0] rf_q [NREG];
  logic [DATA_W-1:0] rf_d [NREG];
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [3:0] op_q, op_d;
  logic z_q, z_d;
  pipe_t s1_q, s1_d, s2_q, s2_d;
  logic stall, fwd_a, fwd_b, fire, alu_wb;
  opreg_hazard u_hazard (
    .s1(s1_q), .s2(s2_q), .rs_a(rs_a), .rs_b(rs_b), .use_imm(use_imm),
    .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b)
  );
  // issue, writeback arbitration and next-state; ALU writeback beats external writes
  always_comb begin
    alu_wb = s2_q.valid & s2_q.wb_en & (s2_q.rd != '0);
    issue_ready = !RST & !stall;
    ext_wr_ready = !RST & !alu_wb;
    busy = s1_q.valid | s2_q.valid;
    fire = issue_valid & issue_ready;
    rf_d = rf_q;
    if (ext_wr_en & ext_wr_ready & (ext_wr_addr != '0)) rf_d[ext_wr_addr] = ext_wr_data;
    if (alu_wb) rf_d[s2_q.rd] = alu_result;
    a_d = fire ? (fwd_a ? alu_result : rf_q[rs_a]) : a_q;
    b_d = fire ? (use_imm ? imm_in : fwd_b ? alu_result : rf_q[rs_b]) : b_q;
    op_d = fire ? op_in : NOP;
    s1_d = fire ? pipe_t'{1'b1, wb_en, rd} : '0;
    s2_d = s1_q;
    z_d = s2_q.valid ? alu_z : z_q;
  end
  // state registers with synchronous reset dropping in-flight writebacks
  always_ff @(posedge clk) begin
    if (RST) begin
      rf_q <= '{default: '0};
      a_q <= '0;
      b_q <= '0;
      op_q <= NOP;
      z_q <= 1'b0;
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      rf_q <= rf_d;
      a_q <= a_d;
      b_q <= b_d;
      op_q <= op_d;
      z_q <= z_d;
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end
  assign ALU_OP = op_q;
  assign a_out = a_q;
  assign b_out = b_q;
  assign z_out = z_q;
endmodule

// File: tb/tb_operand_regfile.sv
// tb_operand_regfile: directed self-checking bench with a registered ALU model
module tb_operand_regfile;
  logic clk = 0, RST = 1;
  logic issue_valid = 0, issue_ready;
  logic [3:0] op_in = 0;
  logic [2:0] rs_a = 0, rs_b = 0, rd = 0;
  logic use_imm = 0, wb_en = 0;
  logic [18:0] imm_in = 0;
  logic [3:0] ALU_OP;
  logic [18:0] a_out, b_out, alu_result;
  logic alu_z;
  logic ext_wr_en = 0;
  logic [2:0] ext_wr_addr = 0;
  logic [18:0] ext_wr_data = 0;
  logic ext_wr_ready, z_out, busy;
  int checks = 0, passed = 0, s;
  localparam logic [3:0] ADD = 4'h0, SUB = 4'h1, INC = 4'h2;

  operand_regfile dut (
    .clk(clk), .RST(RST), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .op_in(op_in), .rs_a(rs_a), .rs_b(rs_b), .rd(rd), .use_imm(use_imm),
    .imm_in(imm_in), .wb_en(wb_en), .ALU_OP(ALU_OP), .a_out(a_out), .b_out(b_out),
    .alu_result(alu_result), .alu_z(alu_z), .ext_wr_en(ext_wr_en),
    .ext_wr_addr(ext_wr_addr), .ext_wr_data(ext_wr_data), .ext_wr_ready(ext_wr_ready),
    .z_out(z_out), .busy(busy)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk)
    alu_result <= (ALU_OP == ADD) ? a_out + b_out :
                  (ALU_OP == SUB) ? a_out - b_out :
                  (ALU_OP == INC) ? a_out + 19'd1 : 19'd0;
  assign alu_z = (alu_result == 19'd0);

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, o, e);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [3:0] op, input logic [2:0] d, a, b,
                       input logic im, input logic [18:0] imm, input logic wb,
                       output int stalls);
    op_in = op; rd = d; rs_a = a; rs_b = b; use_imm = im; imm_in = imm; wb_en = wb;
    issue_valid = 1;
    stalls = 0;
    #1;
    while (!issue_ready && stalls < 8) begin
      tick();
      stalls++;
      #1;
    end
    if (!issue_ready) chk("issue_timeout", issue_ready, 1);
    tick();
    issue_valid = 0;
  endtask

  task automatic ext_wr(input logic [2:0] a, input logic [18:0] d);
    ext_wr_en = 1; ext_wr_addr = a; ext_wr_data = d;
    tick();
    ext_wr_en = 0;
  endtask

  task automatic rd_reg(input string tag, input logic [2:0] a, input logic [18:0] e);
    int st;
    issue(ADD, 3'd0, a, 3'd0, 1'b1, 19'd0, 1'b0, st);
    chk(tag, a_out, e);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 10) begin
      tick();
      n++;
    end
    if (busy) chk("idle_timeout", busy, 0);
  endtask

  initial begin
    issue_valid = 1;
    tick();
    tick();
    #1;
    chk("rst_issue_ready", issue_ready, 0);
    chk("rst_ext_ready", ext_wr_ready, 0);
    issue_valid = 0;
    RST = 0;
    tick();
    chk("rst_op", ALU_OP, 4'hF);
    chk("rst_a", a_out, 0);
    chk("rst_b", b_out, 0);
    chk("rst_z", z_out, 0);
    chk("rst_busy", busy, 0);

    ext_wr(3'd1, 19'd5);
    ext_wr(3'd2, 19'd3);
    issue(ADD, 3'd3, 3'd1, 3'd2, 1'b0, 19'd0, 1'b1, s);
    chk("add_stalls", s, 0);
    chk("add_a", a_out, 5);
    chk("add_b", b_out, 3);
    chk("add_op", ALU_OP, ADD);
    chk("add_busy", busy, 1);
    tick();
    tick();
    chk("add_z", z_out, 0);
    rd_reg("r3", 3'd3, 19'd8);

    wait_idle();
    issue(SUB, 3'd4, 3'd1, 3'd1, 1'b0, 19'd0, 1'b1, s);
    tick();
    tick();
    chk("sub_z", z_out, 1);
    rd_reg("r4", 3'd4, 19'd0);
    wait_idle();
    issue(ADD, 3'd5, 3'd0, 3'd0, 1'b1, 19'd7, 1'b1, s);
    tick();
    tick();
    chk("addi_z", z_out, 0);
    ext_wr(3'd0, 19'd9);
    rd_reg("r0", 3'd0, 19'd0);
    rd_reg("r5", 3'd5, 19'd7);

    wait_idle();
    issue(ADD, 3'd3, 3'd1, 3'd2, 1'b0, 19'd0, 1'b1, s);
    issue(ADD, 3'd6, 3'd3, 3'd3, 1'b0, 19'd0, 1'b1, s);
`ifdef OPREG_BYPASS_EN
    chk("dep_stalls", s, 1);
`else
    chk("dep_stalls", s, 2);
`endif
    chk("dep_a", a_out, 8);
    chk("dep_b", b_out, 8);
    wait_idle();
    rd_reg("r6", 3'd6, 19'd16);

    wait_idle();
    issue(ADD, 3'd2, 3'd1, 3'd1, 1'b0, 19'd0, 1'b1, s);
    tick();
    ext_wr_en = 1; ext_wr_addr = 3'd7; ext_wr_data = 19'h55;
    #1;
    chk("conflict_ready", ext_wr_ready, 0);
    tick();
    #1;
    chk("retry_ready", ext_wr_ready, 1);
    tick();
    ext_wr_en = 0;
    rd_reg("r2", 3'd2, 19'd10);
    rd_reg("r7", 3'd7, 19'h55);

    wait_idle();
    rd_reg("r0_again", 3'd0, 19'd0);
    wait_idle();
    chk("pre_rst_z", z_out, 1);
    issue(ADD, 3'd4, 3'd1, 3'd2, 1'b0, 19'd0, 1'b1, s);
    RST = 1;
    tick();
    RST = 0;
    tick();
    chk("drop_op", ALU_OP, 4'hF);
    chk("drop_busy", busy, 0);
    chk("drop_z", z_out, 0);
    tick();
    rd_reg("drop_r4", 3'd4, 19'd0);
    rd_reg("drop_r1", 3'd1, 19'd0);

    wait_idle();
    ext_wr(3'd1, 19'h100);
    op_in = INC; rs_a = 3'd1; rs_b = 3'd0; use_imm = 0; wb_en = 1;
    for (int i = 0; i < 8; i++) begin
      rd = 3'(2 + (i % 6));
      issue_valid = 1;
      #1;
      chk("b2b_ready", issue_ready, 1);
      tick();
      chk("b2b_op", ALU_OP, INC);
      chk("b2b_busy", busy, 1);
    end
    issue_valid = 0;
    tick();
    chk("b2b_tail1", busy, 1);
    tick();
    chk("b2b_tail2", busy, 0);
    for (int r = 2; r < 8; r++) rd_reg("b2b_reg", 3'(r), 19'h101);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
